// File: rtl/line_sensor_adc.sv
// Round-robin reader for three line sensors on an ADC128S022-style SPI ADC.
// Re-orders the pipelined conversions and publishes a hysteresis-thresholded left/center/right snapshot.
module line_sensor_adc #(
   parameter int         CLK_DIV   = 25,
   parameter int         THRESHOLD = 1500,
   parameter int         HYST      = 100,
   parameter int         LINE_HIGH = 1,
   parameter logic [2:0] CH_LEFT   = 3'd0,
   parameter logic [2:0] CH_CENTER = 3'd1,
   parameter logic [2:0] CH_RIGHT  = 3'd2
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       adc_cs_n,
   output logic       adc_sck,
   output logic       adc_din,
   input  logic       adc_dout,
   output logic [2:0] adc_data,
   output logic       sample_valid
);

   localparam int            CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   localparam logic [1:0] IDLE_GAP = 2'd0;
   localparam logic [1:0] CS_SETUP = 2'd1;
   localparam logic [1:0] SHIFT    = 2'd2;
   localparam logic [1:0] CS_HOLD  = 2'd3;

   localparam logic [1:0] SEL_LEFT   = 2'd0;
   localparam logic [1:0] SEL_CENTER = 2'd1;
   localparam logic [1:0] SEL_RIGHT  = 2'd2;

   localparam logic [12:0] LEVEL_HI = 13'(THRESHOLD + HYST);
   localparam logic [12:0] LEVEL_LO = 13'(THRESHOLD - HYST);

   logic [CW-1:0] div_cnt;
   logic          tick;
   logic [1:0]    state;
   logic [3:0]    bit_idx;
   logic [11:0]   shift_reg;
   logic [1:0]    addr_sel;
   logic [1:0]    data_sel;
   logic          primed;
   logic          conv_done;
   logic          publish;
   logic [2:0]    frame_addr;
   logic          frame_bit;
   logic [2:0]    s;
   logic [12:0]   value13;
   logic          above;
   logic          below;
   logic          set_s;
   logic          clr_s;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_comb begin
      frame_addr = CH_RIGHT;
      case (addr_sel)
         SEL_LEFT:   frame_addr = CH_LEFT;
         SEL_CENTER: frame_addr = CH_CENTER;
         default:    frame_addr = CH_RIGHT;
      endcase
   end

   // Address occupies frame bits 2..4 (ADD2..ADD0); every other bit shifted out is zero.
   always_comb begin
      frame_bit = 1'b0;
      case (bit_idx)
         4'd2:    frame_bit = frame_addr[2];
         4'd3:    frame_bit = frame_addr[1];
         4'd4:    frame_bit = frame_addr[0];
         default: frame_bit = 1'b0;
      endcase
   end

   // Frame sequencer: data_sel trails addr_sel by one frame because the ADC returns
   // the conversion addressed in the previous frame; primed drops the first frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CS_SETUP;
         adc_cs_n  <= 1'b1;
         adc_sck   <= 1'b1;
         adc_din   <= 1'b0;
         bit_idx   <= 4'd0;
         shift_reg <= 12'd0;
         addr_sel  <= SEL_LEFT;
         data_sel  <= SEL_LEFT;
         primed    <= 1'b0;
         conv_done <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         if (tick) begin
            case (state)
               CS_SETUP: begin
                  adc_cs_n <= 1'b0;
                  adc_sck  <= 1'b1;
                  adc_din  <= 1'b0;
                  bit_idx  <= 4'd0;
                  state    <= SHIFT;
               end
               SHIFT: begin
                  if (adc_sck) begin
                     adc_sck <= 1'b0;
                     adc_din <= frame_bit;
                  end else begin
                     adc_sck <= 1'b1;
                     if (bit_idx >= 4'd4) begin
                        shift_reg <= {shift_reg[10:0], adc_dout};
                     end
                     if (bit_idx == 4'd15) begin
                        state     <= CS_HOLD;
                        conv_done <= primed;
                     end
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
               CS_HOLD: begin
                  adc_cs_n <= 1'b1;
                  adc_sck  <= 1'b1;
                  adc_din  <= 1'b0;
                  data_sel <= addr_sel;
                  addr_sel <= (addr_sel == SEL_RIGHT) ? SEL_LEFT : addr_sel + 2'd1;
                  primed   <= 1'b1;
                  state    <= CS_SETUP;
               end
               IDLE_GAP: begin
                  adc_cs_n <= 1'b1;
                  adc_sck  <= 1'b1;
                  adc_din  <= 1'b0;
                  state    <= CS_SETUP;
               end
            endcase
         end
      end
   end

   assign value13 = {1'b0, shift_reg};
   assign above   = (value13 > LEVEL_HI);
   assign below   = (value13 < LEVEL_LO);
   assign set_s   = (LINE_HIGH != 0) ? above : below;
   assign clr_s   = (LINE_HIGH != 0) ? below : above;

   function automatic logic next_s(input logic cur, input logic set_i, input logic clr_i);
      if (set_i) begin
         return 1'b1;
      end else if (clr_i) begin
         return 1'b0;
      end
      return cur;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s       <= 3'b000;
         publish <= 1'b0;
      end else begin
         publish <= 1'b0;
         if (conv_done) begin
            case (data_sel)
               SEL_LEFT:   s[2] <= next_s(s[2], set_s, clr_s);
               SEL_CENTER: s[1] <= next_s(s[1], set_s, clr_s);
               default:    s[0] <= next_s(s[0], set_s, clr_s);
            endcase
            publish <= (data_sel == SEL_RIGHT);
         end
      end
   end

   // The bus only moves on publish, so a round is always seen as a whole.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adc_data     <= 3'b000;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= publish;
         if (publish) begin
            adc_data <= s;
         end
      end
   end

   a_valid_pulse : assert property (@(posedge clk) disable iff (!rst_n) sample_valid |=> !sample_valid);
   a_cs_sck_idle : assert property (@(posedge clk) disable iff (!rst_n) adc_cs_n |-> adc_sck);

endmodule
